avr_dmem_arbiter: RTL



---
 rtl/avr_pkg.sv | 19 +
 rtl/avr_starve_cnt.sv | 36 +++
 rtl/avr_dmem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/avr_pkg.sv
// Shared AVR data-memory definitions: SRAM widths, arbiter owner and state encodings.
package avr_pkg;

    localparam int AVR_AW     = 16;
    localparam int AVR_DW     = 8;
    localparam int STARVE_W   = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } own_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/avr_starve_cnt.sv
// Saturating count of consecutive denied DMA cycles, with a threshold flag
// that fires once the count reaches LIMIT-1.
module avr_starve_cnt
    import avr_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                denied,
    output logic [STARVE_W-1:0] cnt,
    output logic                thr
);

    localparam logic [STARVE_W-1:0] CNT_MAX = {STARVE_W{1'b1}};
    localparam logic [STARVE_W-1:0] THR_VAL = STARVE_W'(LIMIT - 1);

    // Count each denied cycle, saturate at all-ones, restart on any non-denied cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (denied) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + STARVE_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Threshold reached; >= keeps the flag asserted while saturating in FORCE.
    always_comb begin
        thr = (cnt >= THR_VAL);
    end

endmodule

// File: rtl/avr_dmem_arbiter.sv
// Single-port data SRAM arbiter between the AVR core (fixed priority) and a
// secondary DMA/debug port. A starvation counter forces a CPU hold so the
// secondary port eventually gets exactly one access per hold episode.
module avr_dmem_arbiter
    import avr_pkg::*;
#(
    parameter int AW           = AVR_AW,
    parameter int DW           = AVR_DW,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    own_e                owner;
    arb_state_e          state_q;
    arb_state_e          state_d;
    logic                denied;
    logic                thr;
    logic [STARVE_W-1:0] starve_cnt;

    // Fixed-priority owner selection: the CPU is never refused.
    always_comb begin
        owner = OWN_NONE;
        if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

    // SRAM mux; write enable and grant are gated by reset, address/data are not.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        dma_gnt   = 1'b0;
        case (owner)
            OWN_CPU: begin
                mem_we = cpu_we & RST_N;
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_we & RST_N;
                dma_gnt   = RST_N;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign denied    = dma_req & ~dma_gnt;

    avr_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .denied (denied),
        .cnt    (starve_cnt),
        .thr    (thr)
    );

    // Arbiter state register; reset drops the CPU hold immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter FORCE on the starving denied cycle; leave after one grant or if DMA gives up.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (denied && thr) begin
                    state_d = FORCE;
                end
            end
            FORCE: begin
                if (dma_gnt || !dma_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cpu_hold = (state_q == FORCE);

    // DMA read data is valid the cycle after a granted read; reset cancels it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dma_rvalid <= 1'b0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
        end
    end

endmodule
